vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Produces the pixel raster that the drawing modules consume.
- Generates `pixelX`/`pixelY` for every pixel slot of a 640x480@60 frame, including blanking.
- Takes back the merged 8-bit RGB word (R3G3B2) from the draw/mux chain, aligns it with delayed sync and blank signals, and drives the VGA DAC pins.
- Sits at the top of the video path: draw modules on one side, board VGA connector on the other.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525
- CLK_DIV, 2, `clk` cycles per pixel (1..4)
- PIPE_DLY, 1, `clk` cycles from `pixelX`/`pixelY` change to matching `RGBin` (0..7)
- SYNC_POL, 0, asserted level of `hSync`/`vSync`

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- RGBin  in  8  {R[2:0],G[2:0],B[1:0]} from draw chain, PIPE_DLY clocks after coordinates
- pixelX  out  11  horizontal counter, 0..H_TOTAL-1
- pixelY  out  11  vertical counter, 0..V_TOTAL-1
- pixelEnable  out  1  one-clk strobe marking a pixel advance
- startOfFrame  out  1  one-clk pulse at frame start
- red  out  8  DAC red
- green  out  8  DAC green
- blue  out  8  DAC blue
- hSync  out  1  horizontal sync
- vSync  out  1  vertical sync
- blankN  out  1  high during visible region (aligned with RGB)

Behaviour:
- **Clock and reset:** one clock domain, `clk`. `resetN` is asynchronous and active-low. While reset is asserted:
  - div counter = 0
  - `pixelX` = `pixelY` = 0
  - `pixelEnable` = 0, `startOfFrame` = 0
  - `red`/`green`/`blue` = 0, `blankN` = 0
  - `hSync` = `vSync` = ~SYNC_POL
  - delay line cleared to inactive/blank
- **Divider:** counts 0..CLK_DIV-1 and wraps. `pixelEnable` is registered high for exactly one `clk` when div = CLK_DIV-1; with CLK_DIV=1 it is constantly 1 after reset.
- **Horizontal counter:** `pixelX` advances only on `pixelEnable`. At H_TOTAL-1 it wraps to 0.
- **Vertical counter:** `pixelY` increments in the same cycle `pixelX` wraps. At V_TOTAL-1 it wraps to 0.
- **Counter timing:** both counters are registered outputs. First advance after reset release occurs CLK_DIV clocks later.
- **startOfFrame:** high for one `clk` in the cycle where the counters become (0,0) via wrap. It is not asserted out of reset.
- **Raw timing signals**, decoded from the current counters:
  - active = `pixelX` < H_ACTIVE && `pixelY` < V_ACTIVE
  - hs = `pixelX` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; default [656,751]
  - vs = `pixelY` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; default [490,491]
- **Alignment:** active/hs/vs pass through a PIPE_DLY-stage shift register, clocked every `clk`, then one output register stage. `RGBin` passes through the output register only. Result:
  - sync, blank and colour all appear at the pins PIPE_DLY+1 clocks after the corresponding coordinate.
  - PIPE_DLY=0 bypasses the shift register.
- **Colour expansion** (registered):
  - `red` = {R,R,R[2:1]}
  - `green` = {G,G,G[2:1]}
  - `blue` = {B,B,B,B}
  - e.g. R=3'b101 -> `red` = 8'hB6.
- **Blanking:** when delayed active = 0, `red`/`green`/`blue` are forced to 0 and `blankN` = 0, regardless of `RGBin`.
- **Sync polarity:** `hSync` = delayed hs ? SYNC_POL : ~SYNC_POL; `vSync` likewise.
- **Arithmetic:** all comparisons are unsigned 11-bit. Counters never exceed TOTAL-1; no illegal states.
- **Reset mid-frame:** immediate return to reset values; the raster restarts at (0,0) with no partial sync pulse carried over.
- **Simultaneous events:** the frame wrap makes both counters and `startOfFrame` update in the same cycle. The vs window is evaluated on the new `pixelY`.

Test Plan:
- Reset release, CLK_DIV=2:
  - first `pixelEnable` 2 clks after release.
  - `pixelX` steps 0,1,2 every 2 clks.
  - `pixelY` = 0 until `pixelX` wraps 799->0, then 1.
- Horizontal timing:
  - `hSync` period = 1600 clks.
  - low width = 192 clks (SYNC_POL=0).
  - falling edge PIPE_DLY+1 clks after `pixelX` becomes 656.
- Vertical timing:
  - `vSync` period = 525 lines = 840000 clks.
  - low width = 2 lines = 3200 clks.
  - `startOfFrame` exactly once per 840000 clks, coincident with `pixelX`=`pixelY`=0.
- Colour path:
  - `RGBin` = 8'hE0 during active -> `red`=FF, `green`=00, `blue`=00.
  - 8'h1F -> `red`=00, `green`=FF, `blue`=FF.
  - 8'hA5 -> `red`=B6, `green`=24, `blue`=55.
  - Each value appears 1 clk after `RGBin`; `blankN`=1.
- Blanking: `RGBin` held 8'hFF for a whole frame -> RGB=0 and `blankN`=0 whenever delayed `pixelX` >= 640 or `pixelY` >= 480.
- Reset mid-frame: assert `resetN`=0 at `pixelY`=300, `pixelX`=700 (inside `hSync`) -> outputs immediately at reset values; after release the raster restarts at (0,0) and the next `hSync` falls at `pixelX`=656 of line 0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Video-path bundle between the draw chain and the VGA timing core.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic [7:0]  RGBin;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        pixelEnable;
  logic        startOfFrame;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hSync;
  logic        vSync;
  logic        blankN;

  modport master (
    input  RGBin,
    output pixelX, pixelY, pixelEnable, startOfFrame,
    output red, green, blue, hSync, vSync, blankN
  );

  modport slave (
    output RGBin,
    input  pixelX, pixelY, pixelEnable, startOfFrame,
    input  red, green, blue, hSync, vSync, blankN
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 raster counters plus sync/blank/colour alignment to DAC.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_DLY = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         resetN,
  vga_timing_gen_if.master  vga
);

  localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
  localparam logic [10:0] c_h_last   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] c_v_active = 11'(V_ACTIVE);
  localparam logic [10:0] c_v_last   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [1:0]  c_div_last = 2'(CLK_DIV - 1);

  logic [1:0]  r_div;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_pe;
  logic        r_sof;
  logic        w_tick;
  logic        w_x_wrap;
  logic        w_y_wrap;
  logic [2:0]  w_raw;   // {active, hs, vs}
  logic [2:0]  w_dly;
  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic [7:0]  r_blue;
  logic        r_blank_n;
  logic        r_hsync;
  logic        r_vsync;

  assign w_tick   = (r_div == c_div_last);
  assign w_x_wrap = (r_x == c_h_last);
  assign w_y_wrap = (r_y == c_v_last);

  // Counters and strobes update on the same edge, so pixelEnable flags the
  // cycle in which the new coordinate is first presented.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_pe  <= 1'b0;
      r_sof <= 1'b0;
    end else begin
      r_div <= w_tick ? 2'd0 : r_div + 2'd1;
      r_pe  <= w_tick;
      r_sof <= w_tick && w_x_wrap && w_y_wrap;
      if (w_tick) begin
        if (w_x_wrap) begin
          r_x <= '0;
          r_y <= w_y_wrap ? 11'd0 : r_y + 11'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  assign w_raw = {(r_x < c_h_active) && (r_y < c_v_active),
                  (r_x >= c_hs_start) && (r_x <= c_hs_end),
                  (r_y >= c_vs_start) && (r_y <= c_vs_end)};

  generate
    if (PIPE_DLY > 0) begin : g_pipe
      logic [2:0] r_pipe [PIPE_DLY];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < PIPE_DLY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_dly = r_pipe[PIPE_DLY-1];
    end else begin : g_bypass
      assign w_dly = w_raw;
    end
  endgenerate

  // Bit replication spreads R3G3B2 across the full 8-bit DAC range.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_blank_n <= 1'b0;
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
    end else begin
      r_blank_n <= w_dly[2];
      r_hsync   <= w_dly[1] ? SYNC_POL : ~SYNC_POL;
      r_vsync   <= w_dly[0] ? SYNC_POL : ~SYNC_POL;
      if (w_dly[2]) begin
        r_red   <= {vga.RGBin[7:5], vga.RGBin[7:5], vga.RGBin[7:6]};
        r_green <= {vga.RGBin[4:2], vga.RGBin[4:2], vga.RGBin[4:3]};
        r_blue  <= {4{vga.RGBin[1:0]}};
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
    end
  end

  assign vga.pixelX       = r_x;
  assign vga.pixelY       = r_y;
  assign vga.pixelEnable  = r_pe;
  assign vga.startOfFrame = r_sof;
  assign vga.red          = r_red;
  assign vga.green        = r_green;
  assign vga.blue         = r_blue;
  assign vga.blankN       = r_blank_n;
  assign vga.hSync        = r_hsync;
  assign vga.vSync        = r_vsync;

endmodule
`default_nettype wire
